// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: staged reset sequencer driven by the board power-on reset.
// Releases NUM_STAGES reset domains in order (bit 0 first). Each stage waits
// a settle delay and then the domain's ready ack before the next release.
// A missing ack times out and restarts the sequence up to MAX_RETRIES times,
// after which a sticky fault is raised. soft_rst_req restarts from any state.
// Optional build macro: RESET_SEQ_LOSS_DETECT_EN restarts the sequence when a
// ready bit falls while in RUN.
module reset_seq_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int STAGE_DELAY = 100,
    parameter int TIMEOUT     = 100000,
    parameter int MAX_RETRIES = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          soft_rst_req,
    input  logic [NUM_STAGES-1:0]         stage_ready,
    output logic [NUM_STAGES-1:0]         stage_rst_n,
    output logic                          all_ready,
    output logic                          fault,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage
);

    localparam int SW      = $clog2(NUM_STAGES);
    localparam int MAX_HS  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int CNT_MAX = (MAX_HS > TIMEOUT) ? MAX_HS : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SETTLE,
        ST_WAIT_ACK,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           retry_cnt_q, retry_cnt_d;
    logic [SW-1:0]           cur_stage_q, cur_stage_d;
    logic [NUM_STAGES-1:0]   stage_rst_n_q, stage_rst_n_d;
    logic                    all_ready_q, all_ready_d;
    logic                    fault_q, fault_d;

    // Resets released so far: every stage up to and including the given one.
    function automatic logic [NUM_STAGES-1:0] release_mask(input logic [SW-1:0] stage);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= int'(stage)) m[i] = 1'b1;
        end
        return m;
    endfunction

`ifdef RESET_SEQ_LOSS_DETECT_EN
    logic [NUM_STAGES-1:0] ready_q, ready_d;
    logic                  ready_lost;

    // Previous ready vector, so a falling bit can be seen in RUN.
    always_comb begin
        ready_d    = stage_ready;
        ready_lost = |(ready_q & ~stage_ready);
    end

    // Ready history register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_q <= '0;
        else          ready_q <= ready_d;
    end
`endif

    // Next-state, counters and registered outputs (derived from the next state
    // so every output changes on the same edge as the state).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        retry_cnt_d   = retry_cnt_q;
        cur_stage_d   = cur_stage_q;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = '0;
                    cur_stage_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(STAGE_DELAY - 1)) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_ACK: begin
                if (stage_ready[cur_stage_q]) begin
                    cnt_d = '0;
                    if (cur_stage_q == SW'(NUM_STAGES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d     = ST_SETTLE;
                        cur_stage_d = cur_stage_q + SW'(1);
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retry_cnt_q < RW'(MAX_RETRIES)) begin
                        state_d     = ST_HOLD;
                        retry_cnt_d = retry_cnt_q + RW'(1);
                        cur_stage_d = '0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_RUN: begin
                cnt_d       = '0;
                retry_cnt_d = '0;
`ifdef RESET_SEQ_LOSS_DETECT_EN
                if (ready_lost) begin
                    state_d     = ST_HOLD;
                    cur_stage_d = '0;
                end
`endif
            end
            ST_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d     = ST_HOLD;
                cnt_d       = '0;
                cur_stage_d = '0;
            end
        endcase

        // Soft request overrides everything and pins the block in HOLD.
        if (soft_rst_req) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            retry_cnt_d = '0;
            cur_stage_d = '0;
        end

        stage_rst_n_d = '0;
        case (state_d)
            ST_SETTLE, ST_WAIT_ACK: stage_rst_n_d = release_mask(cur_stage_d);
            ST_RUN:                 stage_rst_n_d = '1;
            default:                stage_rst_n_d = '0;
        endcase
        all_ready_d = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    // State and output registers; POR drops every stage reset at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            retry_cnt_q   <= '0;
            cur_stage_q   <= '0;
            stage_rst_n_q <= '0;
            all_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            cur_stage_q   <= cur_stage_d;
            stage_rst_n_q <= stage_rst_n_d;
            all_ready_q   <= all_ready_d;
            fault_q       <= fault_d;
        end
    end

    assign stage_rst_n = stage_rst_n_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;
    assign cur_stage   = cur_stage_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with NUM_STAGES=3, HOLD_CYCLES=4,
// STAGE_DELAY=2, TIMEOUT=8, MAX_RETRIES=1.
module tb_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       soft_rst_req;
    logic [2:0] stage_ready;
    logic [2:0] stage_rst_n;
    logic       all_ready;
    logic       fault;
    logic [1:0] cur_stage;

    int checks = 0;
    int errors = 0;

    reset_seq_ctrl #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(4),
        .STAGE_DELAY(2),
        .TIMEOUT    (8),
        .MAX_RETRIES(1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .soft_rst_req(soft_rst_req),
        .stage_ready (stage_ready),
        .stage_rst_n (stage_rst_n),
        .all_ready   (all_ready),
        .fault       (fault),
        .cur_stage   (cur_stage)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        soft_rst_req = 1'b0;
        stage_ready  = 3'b111;
        tick_n(3);
        check("reset_rst_n", stage_rst_n, 3'b000);
        check("reset_all_ready", all_ready, 1'b0);
        check("reset_fault", fault, 1'b0);
        check("reset_cur_stage", cur_stage, 2'd0);

        // 1. Normal bring-up
        reset_n = 1'b1;
        tick_n(3);
        check("t1_hold_e3", stage_rst_n, 3'b000);
        tick();
        check("t1_rel0_e4", stage_rst_n, 3'b001);
        check("t1_cur0_e4", cur_stage, 2'd0);
        tick_n(2);
        check("t1_wait0_e6", stage_rst_n, 3'b001);
        tick();
        check("t1_rel1_e7", stage_rst_n, 3'b011);
        check("t1_cur1_e7", cur_stage, 2'd1);
        tick_n(3);
        check("t1_rel2_e10", stage_rst_n, 3'b111);
        check("t1_cur2_e10", cur_stage, 2'd2);
        tick_n(2);
        check("t1_not_ready_e12", all_ready, 1'b0);
        tick();
        check("t1_all_ready_e13", all_ready, 1'b1);
        check("t1_fault_e13", fault, 1'b0);
        check("t1_rst_e13", stage_rst_n, 3'b111);

        // 2. Timeout / retry then FAULT
        stage_ready = 3'b101;
        soft_pulse();
        check("t2_soft_rst", stage_rst_n, 3'b000);
        check("t2_soft_all_ready", all_ready, 1'b0);
        tick_n(7);
        check("t2_rel1", stage_rst_n, 3'b011);
        tick_n(9);
        check("t2_pre_timeout", stage_rst_n, 3'b011);
        tick();
        check("t2_retry_rst", stage_rst_n, 3'b000);
        check("t2_retry_cur", cur_stage, 2'd0);
        check("t2_retry_fault", fault, 1'b0);
        tick_n(16);
        check("t2_pre_timeout2", stage_rst_n, 3'b011);
        check("t2_pre_fault", fault, 1'b0);
        tick();
        check("t2_fault", fault, 1'b1);
        check("t2_fault_rst", stage_rst_n, 3'b000);
        tick_n(50);
        check("t2_fault_sticky", fault, 1'b1);
        check("t2_fault_rst_hold", stage_rst_n, 3'b000);
        check("t2_fault_all_ready", all_ready, 1'b0);

        // 3. Fault recovery
        stage_ready = 3'b111;
        soft_pulse();
        check("t3_fault_clear", fault, 1'b0);
        check("t3_rst", stage_rst_n, 3'b000);
        tick_n(12);
        check("t3_not_ready", all_ready, 1'b0);
        tick();
        check("t3_all_ready", all_ready, 1'b1);
        check("t3_cur_stage", cur_stage, 2'd2);

        // 4. Ack on the final WAIT_ACK cycle
        stage_ready = 3'b011;
        soft_pulse();
        tick_n(19);
        check("t4_wait_cycle7_ready", all_ready, 1'b0);
        check("t4_wait_cycle7_rst", stage_rst_n, 3'b111);
        stage_ready = 3'b111;
        tick();
        check("t4_run", all_ready, 1'b1);
        check("t4_no_retry_rst", stage_rst_n, 3'b111);
        tick_n(10);
        check("t4_run_stays", all_ready, 1'b1);
        check("t4_fault", fault, 1'b0);

        // 5. Async reset mid-SETTLE
        soft_pulse();
        tick_n(7);
        check("t5_settle1", stage_rst_n, 3'b011);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_rst", stage_rst_n, 3'b000);
        check("t5_async_cur", cur_stage, 2'd0);
        check("t5_async_all_ready", all_ready, 1'b0);
        tick();
        reset_n = 1'b1;

        // Held soft request keeps the block in HOLD with the count cleared
        soft_rst_req = 1'b1;
        tick_n(6);
        check("soft_held_rst", stage_rst_n, 3'b000);
        soft_rst_req = 1'b0;
        tick_n(3);
        check("soft_rel_hold", stage_rst_n, 3'b000);
        tick();
        check("soft_rel_first", stage_rst_n, 3'b001);
        tick_n(9);
        check("soft_rel_run", all_ready, 1'b1);

        // 6. Ready loss in RUN
        stage_ready = 3'b110;
        tick();
        stage_ready = 3'b111;
`ifdef RESET_SEQ_LOSS_DETECT_EN
        check("t6_loss_all_ready", all_ready, 1'b0);
        check("t6_loss_rst", stage_rst_n, 3'b000);
        check("t6_loss_fault", fault, 1'b0);
        tick_n(12);
        check("t6_reseq_pending", all_ready, 1'b0);
        tick();
        check("t6_reseq_run", all_ready, 1'b1);
        check("t6_reseq_fault", fault, 1'b0);
`else
        check("t6_ignore_all_ready", all_ready, 1'b1);
        check("t6_ignore_rst", stage_rst_n, 3'b111);
        tick_n(5);
        check("t6_ignore_later", all_ready, 1'b1);
        check("t6_ignore_fault", fault, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Staged reset sequencer fed by the board power-on reset.
- Releases NUM_STAGES downstream reset domains in fixed order: PLL, SDRAM/VGA, game logic, and so on.
- Each stage waits a settle delay, then waits for that domain's ready acknowledge before the next stage is released.
- Includes timeout/retry, a sticky fault flag and a soft re-sequence request from game logic.

Parameters:
- NUM_STAGES, 4: number of sequenced reset domains (>=2).
- HOLD_CYCLES, 1000: cycles all stage resets stay asserted before the first release.
- STAGE_DELAY, 100: settle cycles after each stage release, before its ack is sampled.
- TIMEOUT, 100000: cycles allowed in WAIT_ACK for the current stage's ack.
- MAX_RETRIES, 3: full re-sequences allowed before FAULT.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset (from POR).
- soft_rst_req, input, 1: synchronous request to restart the sequence; level or pulse.
- stage_ready, input, NUM_STAGES: per-domain ack (PLL lock, init done); assumed synchronous to clk.
- stage_rst_n, output, NUM_STAGES: per-domain active-low resets; bit 0 is released first.
- all_ready, output, 1: high only in RUN.
- fault, output, 1: sticky; retries exhausted.
- cur_stage, output, $clog2(NUM_STAGES): index of the stage being released or awaited.

Behaviour:
- Reset (reset_n=0, async), all registered:
  - state=HOLD, cnt=0, retry_cnt=0.
  - stage_rst_n=0, all_ready=0, fault=0, cur_stage=0.
- Counter cnt: width $clog2(max(HOLD_CYCLES,STAGE_DELAY,TIMEOUT)+1); cleared on every state entry.
- HOLD:
  - stage_rst_n=0; cnt increments.
  - When cnt==HOLD_CYCLES-1 → SETTLE with cur_stage=0.
  - stage_rst_n[0] rises on that same edge, so bit 0 rises exactly HOLD_CYCLES edges after HOLD entry.
- SETTLE:
  - stage_rst_n[cur_stage:0]=1; higher bits stay 0.
  - After STAGE_DELAY cycles → WAIT_ACK.
  - stage_ready is ignored in this state.
- WAIT_ACK, when stage_ready[cur_stage]=1:
  - If cur_stage==NUM_STAGES-1 → RUN (all_ready=1 next edge).
  - Otherwise cur_stage++ → SETTLE, and stage_rst_n[cur_stage+1] rises on the same edge.
- WAIT_ACK, when cnt==TIMEOUT-1 without ack:
  - If retry_cnt<MAX_RETRIES: retry_cnt++, → HOLD, all stage_rst_n=0, cur_stage=0.
  - Otherwise → FAULT.
- An ack that arrives on the timeout cycle wins: the stage advances.
- RUN:
  - stage_rst_n all 1, all_ready=1, retry_cnt cleared to 0.
  - Loss monitoring only per Optional Feature.
- FAULT:
  - stage_rst_n all 0, fault=1, all_ready=0.
  - Stays until soft_rst_req or reset_n.
- soft_rst_req=1, highest priority, any state:
  - Next state HOLD; stage_rst_n=0, all_ready=0, fault=0, retry_cnt=0, cur_stage=0.
  - Held high, it keeps the block in HOLD with cnt cleared each cycle.
- Reset mid-operation: all stage resets drop immediately (async), whatever the state.
- stage_ready bits above cur_stage are ignored.
- Released stages' ready bits are ignored before RUN.

Optional Feature:
- Macro RESET_SEQ_LOSS_DETECT_EN.
- Defined: in RUN, any stage_ready bit falling to 0 (e.g. PLL lock loss) → HOLD with retry_cnt=0. This is the same action as soft_rst_req but with lower priority, and fault is not set.
- Undefined: RUN ignores stage_ready entirely; only soft_rst_req or reset_n leave RUN.

Test Plan:
Bench parameters: NUM_STAGES=3, HOLD_CYCLES=4, STAGE_DELAY=2, TIMEOUT=8, MAX_RETRIES=1.
1. Normal bring-up:
   - Stimulus: release reset_n; stage_ready tied to 3'b111.
   - Response: stage_rst_n=000 for 4 edges, then 001; 011 after 2+1 edges; then 111; all_ready=1 at edge 4+3×3; fault=0.
2. Timeout/retry:
   - Stimulus: stage_ready[1] held 0.
   - Response: after 8 WAIT_ACK cycles, stage_rst_n returns to 000 and the sequence restarts. After the second timeout, fault=1 and stage_rst_n=000; it stays so for 50 cycles.
3. Fault recovery:
   - Stimulus: from FAULT, pulse soft_rst_req for 1 cycle with stage_ready=111.
   - Response: fault=0 on the next edge; full sequence reaches all_ready=1.
4. Late ack on the boundary:
   - Stimulus: stage_ready[2] asserted exactly on WAIT_ACK cycle 7.
   - Response: block enters RUN; no retry.
5. Async reset mid-SETTLE:
   - Stimulus: reset_n driven 0 while stage_rst_n=011.
   - Response: stage_rst_n=000 and cur_stage=0 before the next clk edge.
6. Loss of lock in RUN:
   - Stimulus: in RUN, drop stage_ready[0] for 1 cycle.
   - Response with RESET_SEQ_LOSS_DETECT_EN: all_ready=0, stage_rst_n=000, full re-sequence, fault=0.
   - Response without it: all_ready stays 1.
